// File: rtl/profile_seq.sv
// Segment sequencer: paces acc_step ticks, loads segments into the profile
// generator's parameter memory and disables channels whose step budget runs out.
module profile_seq #(
    parameter int PERIOD_BITS = 32,
    parameter int LEN_BITS    = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic [PERIOD_BITS-1:0] period,
    input  logic                   seg_valid,
    output logic                   seg_ready,
    input  logic [2:0]             seg_channel,
    input  logic [LEN_BITS-1:0]    seg_len,
    input  logic [63:0]            seg_a,
    input  logic [63:0]            seg_j,
    input  logic [63:0]            seg_jj,
    input  logic                   gen_busy,
    input  logic                   gen_done,
    output logic                   acc_step,
    output logic [7:0]             param_addr,
    output logic [31:0]            param_in,
    output logic                   param_write_lo,
    output logic                   param_write_hi,
    output logic [7:0]             active,
    output logic [7:0]             seg_end,
    output logic                   overrun
);

    typedef enum logic [1:0] {S_IDLE, S_STEP, S_LOAD, S_CLEAR} state_t;

    localparam logic [4:0] REG_STATUS = 5'd0;
    localparam logic [4:0] REG_A      = 5'd4;
    localparam logic [4:0] REG_J      = 5'd5;
    localparam logic [4:0] REG_JJ     = 5'd6;

    state_t                        state_q, state_d;
    logic [2:0]                    beat_q, beat_d;
    logic [2:0]                    ch_q, ch_d;
    logic [LEN_BITS-1:0]           len_q, len_d;
    logic [63:0]                   a_q, a_d, j_q, j_d, jj_q, jj_d;
    logic [PERIOD_BITS-1:0]        cnt_q, cnt_d;
    logic                          tick_pending_q, tick_pending_d;
    logic [7:0][LEN_BITS-1:0]      rem_q, rem_d;
    logic [7:0]                    expire_q, expire_d;
    logic                          acc_step_q, acc_step_d;
    logic [7:0]                    addr_q, addr_d;
    logic [31:0]                   data_q, data_d;
    logic                          wr_lo_q, wr_lo_d, wr_hi_q, wr_hi_d;
    logic [7:0]                    active_q, active_d;
    logic [7:0]                    seg_end_q, seg_end_d;
    logic                          overrun_q, overrun_d;

    logic [PERIOD_BITS-1:0]        period_m1;
    logic                          wrap;
    logic                          tick_now;
    logic [7:0]                    rest;

    function automatic logic [2:0] lowest_ch(input logic [7:0] m);
        lowest_ch = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (m[i]) lowest_ch = 3'(i);
        end
    endfunction

    // Periods below 2 would make the strobe continuous; clamp to 2.
    assign period_m1 = (period < PERIOD_BITS'(2)) ? PERIOD_BITS'(1) : period - PERIOD_BITS'(1);
    assign wrap      = enable && (cnt_q >= period_m1);
    assign tick_now  = tick_pending_q || wrap;

    always_comb begin
        state_d        = state_q;
        beat_d         = beat_q;
        ch_d           = ch_q;
        len_d          = len_q;
        a_d            = a_q;
        j_d            = j_q;
        jj_d           = jj_q;
        cnt_d          = !enable ? '0 : (wrap ? '0 : cnt_q + PERIOD_BITS'(1));
        tick_pending_d = tick_pending_q || wrap;
        overrun_d      = wrap && tick_pending_q;
        rem_d          = rem_q;
        expire_d       = expire_q;
        acc_step_d     = 1'b0;
        seg_end_d      = '0;
        seg_ready      = 1'b0;
        rest           = '0;

        if (gen_done) begin
            for (int c = 0; c < 8; c++) begin
                if (rem_q[c] != '0) begin
                    rem_d[c] = rem_q[c] - LEN_BITS'(1);
                    if (rem_q[c] == LEN_BITS'(1)) expire_d[c] = 1'b1;
                end
            end
        end

        case (state_q)
            S_IDLE: begin
                if (|expire_q) begin
                    state_d = S_CLEAR;
                    beat_d  = 3'd0;
                    ch_d    = lowest_ch(expire_q);
                end else if (tick_now && !gen_busy) begin
                    acc_step_d     = 1'b1;
                    tick_pending_d = tick_pending_q && wrap;
                    state_d        = S_STEP;
                end else begin
                    seg_ready = (rem_q[seg_channel] == '0) && !expire_q[seg_channel] && !gen_busy;
                    if (seg_ready && seg_valid) begin
                        ch_d  = seg_channel;
                        len_d = seg_len;
                        a_d   = seg_a;
                        j_d   = seg_j;
                        jj_d  = seg_jj;
                        if (seg_len != '0) begin
                            state_d = S_LOAD;
                            beat_d  = 3'd0;
                        end
                    end
                end
            end
            S_STEP: begin
                if (gen_done) state_d = S_IDLE;
            end
            S_LOAD: begin
                if (beat_q == 3'd7) begin
                    rem_d[ch_q] = len_q;
                    state_d     = S_IDLE;
                end else begin
                    beat_d = beat_q + 3'd1;
                end
            end
            S_CLEAR: begin
                if (beat_q == 3'd1) begin
                    expire_d[ch_q]  = 1'b0;
                    seg_end_d[ch_q] = 1'b1;
                    rest            = expire_d;
                    // Chain straight into the next expired channel so a burst
                    // of expiries drains before any further step.
                    if (|rest) begin
                        ch_d   = lowest_ch(rest);
                        beat_d = 3'd0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    beat_d = 3'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        for (int c = 0; c < 8; c++) active_d[c] = (rem_d[c] != '0);
    end

    // Write-port outputs are registered from the next state/beat so each
    // beat's strobe lines up with the cycle the FSM spends on that beat.
    always_comb begin
        wr_lo_d = 1'b0;
        wr_hi_d = 1'b0;
        addr_d  = '0;
        data_d  = '0;
        if (state_d == S_LOAD) begin
            wr_lo_d = ~beat_d[0];
            wr_hi_d = beat_d[0];
            case (beat_d[2:1])
                2'd0: begin
                    addr_d = {ch_d, REG_A};
                    data_d = beat_d[0] ? a_d[63:32] : a_d[31:0];
                end
                2'd1: begin
                    addr_d = {ch_d, REG_J};
                    data_d = beat_d[0] ? j_d[63:32] : j_d[31:0];
                end
                2'd2: begin
                    addr_d = {ch_d, REG_JJ};
                    data_d = beat_d[0] ? jj_d[63:32] : jj_d[31:0];
                end
                default: begin
                    addr_d = {ch_d, REG_STATUS};
                    data_d = beat_d[0] ? 32'h0 : 32'h1;
                end
            endcase
        end else if (state_d == S_CLEAR) begin
            wr_lo_d = ~beat_d[0];
            wr_hi_d = beat_d[0];
            addr_d  = {ch_d, REG_STATUS};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            beat_q         <= '0;
            ch_q           <= '0;
            len_q          <= '0;
            a_q            <= '0;
            j_q            <= '0;
            jj_q           <= '0;
            cnt_q          <= '0;
            tick_pending_q <= 1'b0;
            rem_q          <= '0;
            expire_q       <= '0;
            acc_step_q     <= 1'b0;
            addr_q         <= '0;
            data_q         <= '0;
            wr_lo_q        <= 1'b0;
            wr_hi_q        <= 1'b0;
            active_q       <= '0;
            seg_end_q      <= '0;
            overrun_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            beat_q         <= beat_d;
            ch_q           <= ch_d;
            len_q          <= len_d;
            a_q            <= a_d;
            j_q            <= j_d;
            jj_q           <= jj_d;
            cnt_q          <= cnt_d;
            tick_pending_q <= tick_pending_d;
            rem_q          <= rem_d;
            expire_q       <= expire_d;
            acc_step_q     <= acc_step_d;
            addr_q         <= addr_d;
            data_q         <= data_d;
            wr_lo_q        <= wr_lo_d;
            wr_hi_q        <= wr_hi_d;
            active_q       <= active_d;
            seg_end_q      <= seg_end_d;
            overrun_q      <= overrun_d;
        end
    end

    assign acc_step       = acc_step_q;
    assign param_addr     = addr_q;
    assign param_in       = data_q;
    assign param_write_lo = wr_lo_q;
    assign param_write_hi = wr_hi_q;
    assign active         = active_q;
    assign seg_end        = seg_end_q;
    assign overrun        = overrun_q;

endmodule

// File: tb/tb_profile_seq.sv
// Self-checking bench for profile_seq: scoreboarded parameter writes and
// seg_end pulses, with a small generator model answering each acc_step.
module tb_profile_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic [31:0] period = 32'd10;
    logic        seg_valid = 1'b0;
    logic        seg_ready;
    logic [2:0]  seg_channel = 3'd0;
    logic [31:0] seg_len = 32'd0;
    logic [63:0] seg_a = '0, seg_j = '0, seg_jj = '0;
    logic        gen_busy;
    logic        gen_done = 1'b0;
    logic        model_busy = 1'b0;
    logic        force_busy = 1'b0;
    logic        acc_step;
    logic [7:0]  param_addr;
    logic [31:0] param_in;
    logic        param_write_lo, param_write_hi;
    logic [7:0]  active, seg_end;
    logic        overrun;

    typedef struct packed {
        logic [7:0]  addr;
        logic [31:0] data;
        logic        hi;
    } wr_t;

    wr_t        wq[$];
    logic [7:0] eq[$];
    wr_t        exp_w;
    logic [7:0] exp_e;

    int         n_vec = 0, n_fail = 0;
    int         step_cnt = 0, ovr_cnt = 0, step_base = 0;
    logic [7:0] end_seen = '0;
    int         gcnt = 0;

    assign gen_busy = model_busy | force_busy;

    always #5 clk = ~clk;

    profile_seq #(.PERIOD_BITS(32), .LEN_BITS(32)) dut (
        .clk(clk), .rst(rst), .enable(enable), .period(period),
        .seg_valid(seg_valid), .seg_ready(seg_ready), .seg_channel(seg_channel),
        .seg_len(seg_len), .seg_a(seg_a), .seg_j(seg_j), .seg_jj(seg_jj),
        .gen_busy(gen_busy), .gen_done(gen_done), .acc_step(acc_step),
        .param_addr(param_addr), .param_in(param_in),
        .param_write_lo(param_write_lo), .param_write_hi(param_write_hi),
        .active(active), .seg_end(seg_end), .overrun(overrun)
    );

    // Generator: busy the cycle after acc_step, done one cycle later.
    always @(posedge clk) begin
        #1;
        gen_done = 1'b0;
        if (gcnt == 1) begin
            model_busy = 1'b0;
            gen_done   = 1'b1;
            gcnt       = 0;
        end else if (acc_step) begin
            model_busy = 1'b1;
            gcnt       = 1;
        end
    end

    always @(negedge clk) begin
        if (acc_step) step_cnt++;
        if (overrun) ovr_cnt++;
        if (param_write_lo || param_write_hi) begin
            n_vec++;
            if (gen_busy) begin
                n_fail++;
                $display("FAIL write_while_busy addr=%h", param_addr);
            end
            if (wq.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_write addr=%h data=%h lo=%b hi=%b",
                         param_addr, param_in, param_write_lo, param_write_hi);
            end else begin
                exp_w = wq.pop_front();
                if (param_addr !== exp_w.addr || param_in !== exp_w.data ||
                    param_write_hi !== exp_w.hi || param_write_lo !== !exp_w.hi) begin
                    n_fail++;
                    $display("FAIL param_write got addr=%h data=%h lo=%b hi=%b want addr=%h data=%h hi=%b",
                             param_addr, param_in, param_write_lo, param_write_hi,
                             exp_w.addr, exp_w.data, exp_w.hi);
                end
            end
        end
        if (seg_end != 8'h0) begin
            n_vec++;
            end_seen = end_seen | seg_end;
            if (eq.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_seg_end got=%h", seg_end);
            end else begin
                exp_e = eq.pop_front();
                if (seg_end !== exp_e) begin
                    n_fail++;
                    $display("FAIL seg_end got=%h want=%h", seg_end, exp_e);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog_timeout");
        $fatal(1);
    end

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_clear(input logic [2:0] ch);
        wr_t w;
        w.addr = {ch, 5'd0};
        w.data = 32'h0;
        w.hi   = 1'b0;
        wq.push_back(w);
        w.hi   = 1'b1;
        wq.push_back(w);
        eq.push_back(8'h1 << ch);
    endtask

    // Presents a segment until accepted (or bound runs out); on accept the
    // first npush expected load writes go to the scoreboard. Returns one
    // posedge+1 after the transfer edge.
    task automatic send_seg(input logic [2:0] ch, input logic [31:0] len,
                            input logic [63:0] a, input logic [63:0] j, input logic [63:0] jj,
                            input int npush, input int bound, output bit ok);
        logic [31:0] d[8];
        logic [4:0]  r[8];
        wr_t         w;
        d = '{a[31:0], a[63:32], j[31:0], j[63:32], jj[31:0], jj[63:32], 32'h1, 32'h0};
        r = '{5'd4, 5'd4, 5'd5, 5'd5, 5'd6, 5'd6, 5'd0, 5'd0};
        ok = 1'b0;
        @(posedge clk);
        #1;
        seg_channel = ch;
        seg_len     = len;
        seg_a       = a;
        seg_j       = j;
        seg_jj      = jj;
        seg_valid   = 1'b1;
        for (int i = 0; i < bound && !ok; i++) begin
            @(negedge clk);
            if (seg_ready) begin
                ok = 1'b1;
                for (int k = 0; k < npush; k++) begin
                    w.addr = {ch, r[k]};
                    w.data = d[k];
                    w.hi   = ((k % 2) == 1);
                    wq.push_back(w);
                end
            end
            @(posedge clk);
            #1;
        end
        seg_valid = 1'b0;
    endtask

    task automatic test_reset;
        cycles(3);
        n_vec++;
        if ({acc_step, param_write_lo, param_write_hi, active, seg_end, overrun} !== 13'h0) begin
            n_fail++;
            $display("FAIL reset_outputs got=%h want=0",
                     {acc_step, param_write_lo, param_write_hi, active, seg_end, overrun});
        end
        rst = 1'b0;
        cycles(2);
        n_vec++;
        if ({acc_step, param_write_lo, param_write_hi, active, seg_end, overrun} !== 13'h0) begin
            n_fail++;
            $display("FAIL post_reset_idle got=%h want=0",
                     {acc_step, param_write_lo, param_write_hi, active, seg_end, overrun});
        end
    endtask

    task automatic test_basic_load;
        bit ok;
        period = 32'd10;
        enable = 1'b1;
        send_seg(3'd2, 32'd3, 64'h0000_0001_0000_0002, 64'h0, 64'h0, 8, 40, ok);
        step_base = step_cnt;
        n_vec++;
        if (ok !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_accept got=%b want=1", ok);
        end
        cycles(7);
        n_vec++;
        if (active !== 8'h00) begin
            n_fail++;
            $display("FAIL active_before_last_beat got=%h want=00", active);
        end
        cycles(1);
        n_vec++;
        if (active !== 8'h04) begin
            n_fail++;
            $display("FAIL active_after_load got=%h want=04", active);
        end
    endtask

    task automatic test_expiry;
        int i;
        push_clear(3'd2);
        end_seen = '0;
        for (i = 0; i < 200 && !end_seen[2]; i++) cycles(1);
        n_vec++;
        if (!end_seen[2]) begin
            n_fail++;
            $display("FAIL expiry_timeout seg_end[2] got=0 want=1");
        end
        n_vec++;
        if (step_cnt - step_base != 3) begin
            n_fail++;
            $display("FAIL expiry_step_count got=%0d want=3", step_cnt - step_base);
        end
        n_vec++;
        if (active !== 8'h00) begin
            n_fail++;
            $display("FAIL active_after_expiry got=%h want=00", active);
        end
    endtask

    task automatic test_simultaneous_expiry;
        bit ok0, ok7;
        int i;
        enable = 1'b0;
        cycles(8);
        send_seg(3'd0, 32'd1, 64'h1111_2222_3333_4444, 64'h5, 64'hFFFF_FFFF_FFFF_FFFE, 8, 20, ok0);
        send_seg(3'd7, 32'd1, 64'h0, 64'h8000_0000_0000_0001, 64'h7, 8, 20, ok7);
        n_vec++;
        if ({ok0, ok7} !== 2'b11) begin
            n_fail++;
            $display("FAIL simul_accept got=%b want=11", {ok0, ok7});
        end
        push_clear(3'd0);
        push_clear(3'd7);
        step_base = step_cnt;
        end_seen  = '0;
        enable    = 1'b1;
        for (i = 0; i < 150 && !end_seen[7]; i++) cycles(1);
        n_vec++;
        if (end_seen !== 8'h81) begin
            n_fail++;
            $display("FAIL simul_seg_end_seen got=%h want=81", end_seen);
        end
        n_vec++;
        if (step_cnt - step_base != 1) begin
            n_fail++;
            $display("FAIL simul_step_count got=%0d want=1", step_cnt - step_base);
        end
        n_vec++;
        if (active !== 8'h00) begin
            n_fail++;
            $display("FAIL simul_active got=%h want=00", active);
        end
    endtask

    task automatic test_overrun;
        int ob, sb;
        enable = 1'b0;
        cycles(8);
        period     = 32'd2;
        force_busy = 1'b1;
        enable     = 1'b1;
        ob = ovr_cnt;
        sb = step_cnt;
        cycles(10);
        force_busy = 1'b0;
        enable     = 1'b0;
        cycles(10);
        n_vec++;
        if (ovr_cnt - ob != 4) begin
            n_fail++;
            $display("FAIL overrun_count got=%0d want=4", ovr_cnt - ob);
        end
        n_vec++;
        if (step_cnt - sb != 1) begin
            n_fail++;
            $display("FAIL overrun_single_step got=%0d want=1", step_cnt - sb);
        end
        period = 32'd10;
    endtask

    task automatic test_back_pressure;
        bit ok;
        cycles(4);
        send_seg(3'd1, 32'd5, 64'hA, 64'hB, 64'hC, 8, 20, ok);
        n_vec++;
        if (!ok) begin
            n_fail++;
            $display("FAIL bp_load_ch1 got=0 want=1");
        end
        seg_channel = 3'd1;
        seg_len     = 32'd9;
        seg_valid   = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            n_vec++;
            if (seg_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_ready_busy_channel cyc=%0d got=%b want=0", i, seg_ready);
            end
        end
        @(posedge clk);
        #1;
        seg_valid = 1'b0;
        enable    = 1'b1;
        send_seg(3'd3, 32'd1000, 64'h33, 64'h0, 64'h0, 8, 15, ok);
        n_vec++;
        if (!ok) begin
            n_fail++;
            $display("FAIL bp_ch3_immediate got=0 want=1");
        end
        push_clear(3'd1);
        end_seen = '0;
        send_seg(3'd1, 32'd1000, 64'h0123_4567_89AB_CDEF, 64'h0, 64'h1, 8, 300, ok);
        n_vec++;
        if (!ok) begin
            n_fail++;
            $display("FAIL bp_ch1_eventual got=0 want=1");
        end
        n_vec++;
        if (end_seen[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_transfer_before_clear seg_end1_seen=%b want=1", end_seen[1]);
        end
    endtask

    task automatic test_reset_mid_load;
        bit ok;
        enable = 1'b0;
        cycles(12);
        send_seg(3'd5, 32'd7, 64'hDEAD_BEEF_0000_0005, 64'h6, 64'h7, 4, 20, ok);
        n_vec++;
        if (!ok) begin
            n_fail++;
            $display("FAIL rst_load_accept got=0 want=1");
        end
        cycles(3);
        rst = 1'b1;
        cycles(1);
        rst = 1'b0;
        seg_channel = 3'd1;
        @(negedge clk);
        n_vec++;
        if ({param_write_lo, param_write_hi} !== 2'b00) begin
            n_fail++;
            $display("FAIL rst_write_abort got=%b want=00", {param_write_lo, param_write_hi});
        end
        n_vec++;
        if (active !== 8'h00) begin
            n_fail++;
            $display("FAIL rst_active got=%h want=00", active);
        end
        n_vec++;
        if (seg_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_idle_ready_ch1 got=%b want=1", seg_ready);
        end
    endtask

    task automatic test_zero_len;
        bit ok;
        send_seg(3'd4, 32'd0, 64'h99, 64'h98, 64'h97, 0, 10, ok);
        n_vec++;
        if (!ok) begin
            n_fail++;
            $display("FAIL zero_len_transfer got=0 want=1");
        end
        cycles(12);
        n_vec++;
        if (active !== 8'h00) begin
            n_fail++;
            $display("FAIL zero_len_active got=%h want=00", active);
        end
        n_vec++;
        if (wq.size() != 0 || eq.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain writes_left=%0d ends_left=%0d want=0,0",
                     wq.size(), eq.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic_load();
        test_expiry();
        test_simultaneous_expiry();
        test_overrun();
        test_back_pressure();
        test_reset_mid_load();
        test_zero_len();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
